// File: rtl/block_mult_pkg.sv
// Shared block shapes, FSM encodings and single-precision arithmetic helpers for
// the block multiplier and the block accumulator.
package block_mult_pkg;

  localparam int BM_DATA_W = 32;
  localparam int BM_J      = 2;
  localparam int BM_K      = 2;
  localparam int BM_L      = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Denormal inputs/results flush to signed zero; rounding is nearest-even.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [47:0] prod;
    logic [22:0] frac;
    logic        g, st, rnd;
    int          e;
    logic [31:0] r;
    sgn = a[31] ^ b[31];
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0))
      return FP_QNAN;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      return (a[30:23] == '0 || b[30:23] == '0) ? FP_QNAN : {sgn, 8'hFF, 23'd0};
    if (a[30:23] == '0 || b[30:23] == '0)
      return {sgn, 31'd0};
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e    = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) begin
      frac = prod[46:24];
      g    = prod[23];
      st   = |prod[22:0];
      e    = e + 1;
    end else begin
      frac = prod[45:23];
      g    = prod[22];
      st   = |prod[21:0];
    end
    if (e >= 255) return {sgn, 8'hFF, 23'd0};
    if (e <= 0)   return {sgn, 31'd0};
    rnd      = g & (st | frac[0]);
    r        = {sgn, e[7:0], frac};
    r[30:0]  = r[30:0] + {30'd0, rnd};
    return r;
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, r;
    logic [26:0] mx, my, sh;
    logic [27:0] s;
    logic        rnd;
    int          e, d;
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0))
      return FP_QNAN;
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF)
      return (a[31] != b[31]) ? FP_QNAN : a;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    if (a[30:23] == '0 && b[30:23] == '0) return {a[31] & b[31], 31'd0};
    if (a[30:23] == '0) return b;
    if (b[30:23] == '0) return a;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    e  = int'(x[30:23]);
    d  = e - int'(y[30:23]);
    // Bits shifted out of the smaller operand collapse into a sticky LSB.
    if (d > 26) my = 27'd1;
    else begin
      sh = my >> d;
      my = sh | 27'((sh << d) != my);
    end
    if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, my};
    else                s = {1'b0, mx} - {1'b0, my};
    if (s == '0) return 32'd0;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 1;
    end else begin
      for (int unsigned n = 0; n < 26; n++) begin
        if (!s[26]) begin
          s = s << 1;
          e = e - 1;
        end
      end
    end
    if (e >= 255) return {x[31], 8'hFF, 23'd0};
    if (e <= 0)   return {x[31], 31'd0};
    rnd     = s[2] & (s[1] | s[0] | s[3]);
    r       = {x[31], e[7:0], s[25:3]};
    r[30:0] = r[30:0] + {30'd0, rnd};
    return r;
  endfunction

endpackage

// File: rtl/block_mult_mac.sv
// Combinational MAC datapath: one multiply, one add, and a first-term bypass so the
// first product of each dot product is loaded as-is (keeps -0.0 intact).
module mac_unit
  import block_mult_pkg::*;
#(
  parameter int DATA_W = BM_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_acc,
  input  logic              i_first,
  output logic [DATA_W-1:0] o_acc_n
);

  logic [DATA_W-1:0] w_prod;

  always_comb begin
    w_prod  = fp_mul(i_a, i_b);
    o_acc_n = i_first ? w_prod : fp_add(i_acc, w_prod);
  end

endmodule

// File: rtl/block_mult.sv
// Block matrix multiplier P = A(JxL) * B(LxK), one time-multiplexed MAC per cycle,
// loop order i (rows) / j (cols) / l (inner).
module block_mult
  import block_mult_pkg::*;
#(
  parameter int DATA_W = BM_DATA_W,
  parameter int J      = BM_J,
  parameter int K      = BM_K,
  parameter int L      = BM_L
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a_block          [0:J*L-1],
  input  logic [DATA_W-1:0] b_block          [0:L*K-1],
  output logic [DATA_W-1:0] multiplied_block [0:J*K-1],
  output logic              busy,
  output logic              block_mult_done
);

  localparam int IW = cnt_w(J);
  localparam int JW = cnt_w(K);
  localparam int LW = cnt_w(L);
  localparam int AW = cnt_w(J*L);
  localparam int BW = cnt_w(L*K);
  localparam int PW = cnt_w(J*K);

  localparam logic [IW-1:0] I_LAST = IW'(J-1);
  localparam logic [JW-1:0] J_LAST = JW'(K-1);
  localparam logic [LW-1:0] L_LAST = LW'(L-1);

  logic [1:0]        r_state;
  logic [IW-1:0]     r_i;
  logic [JW-1:0]     r_j;
  logic [LW-1:0]     r_l;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_a [0:J*L-1];
  logic [DATA_W-1:0] r_b [0:L*K-1];
  logic [DATA_W-1:0] r_p [0:J*K-1];

  logic [AW-1:0]     w_a_idx;
  logic [BW-1:0]     w_b_idx;
  logic [PW-1:0]     w_p_idx;
  logic [DATA_W-1:0] w_acc_n;

  assign w_a_idx = AW'(int'(r_i) * L + int'(r_l));
  assign w_b_idx = BW'(int'(r_l) * K + int'(r_j));
  assign w_p_idx = PW'(int'(r_i) * K + int'(r_j));

  mac_unit #(.DATA_W(DATA_W)) u_mac (
    .i_a     (r_a[w_a_idx]),
    .i_b     (r_b[w_b_idx]),
    .i_acc   (r_acc),
    .i_first (r_l == '0),
    .o_acc_n (w_acc_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_l     <= '0;
      r_acc   <= '0;
      r_a     <= '{default: '0};
      r_b     <= '{default: '0};
      r_p     <= '{default: '0};
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_MAC;
            r_a     <= a_block;
            r_b     <= b_block;
            r_i     <= '0;
            r_j     <= '0;
            r_l     <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MAC: begin
          r_acc <= w_acc_n;
          if (r_l == L_LAST) begin
            r_p[w_p_idx] <= w_acc_n;
            r_l          <= '0;
            if (r_j == J_LAST) begin
              r_j <= '0;
              if (r_i == I_LAST) begin
                r_i     <= '0;
                r_state <= ST_DONE;
              end else begin
                r_i <= r_i + 1'b1;
              end
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_l <= r_l + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign multiplied_block = r_p;
  assign busy             = (r_state == ST_MAC);
  assign block_mult_done  = (r_state == ST_DONE);

endmodule
